// File: rtl/input_pack_pkg.sv
// rtl/input_pack_pkg.sv - shared constants, state type and word-insert helper for the block packer
//
// Purpose : constants for the Skein-1024 input block packer, the fill-side
//           state encoding, and a helper that drops one word into a block.
// Ports   : none (package).
package input_pack_pkg;

   localparam int WORDS   = 16;
   localparam int WORD_W  = 64;
   localparam int BLOCK_W = WORDS * WORD_W;
   localparam int IDX_W   = 4;
   localparam int CNT_W   = 5;

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   // Word k occupies bits [64k+63:64k], matching the round datapath's word select.
   function automatic logic [BLOCK_W-1:0] insert_word(
      input logic [BLOCK_W-1:0] blk,
      input logic [IDX_W-1:0]   idx,
      input logic [WORD_W-1:0]  w
   );
      logic [BLOCK_W-1:0] r;
      r = blk;
      r[idx*WORD_W +: WORD_W] = w;
      return r;
   endfunction

endpackage

// File: rtl/input_word_writer.sv
// rtl/input_word_writer.sv - block-wide register with clear, indexed word write and whole-block load
//
// Purpose : holds one BLOCK_W block. Used as the fill buffer (indexed word
//           writes) and, in the double-buffer build, as the output register
//           (whole-block load).
// Ports   : clk, rst_n       - clock, asynchronous active-low reset
//           clear            - zero the whole block (highest priority)
//           load, load_block - replace the whole block
//           wr_en, wr_idx,
//           wr_word          - write one word into slice wr_idx
//           block            - current contents
module input_word_writer
   import input_pack_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               load,
   input  logic [BLOCK_W-1:0] load_block,
   input  logic               wr_en,
   input  logic [IDX_W-1:0]   wr_idx,
   input  logic [WORD_W-1:0]  wr_word,
   output logic [BLOCK_W-1:0] block
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         block <= '0;
      end else if (clear) begin
         block <= '0;
      end else if (load) begin
         block <= load_block;
      end else if (wr_en) begin
         block <= insert_word(block, wr_idx, wr_word);
      end
   end

endmodule

// File: rtl/input_block_pack.sv
// rtl/input_block_pack.sv - packs 64-bit words into a zero-padded 1024-bit Skein input block
//
// Purpose : collects up to 16 words into a block, closing on the 16th word or
//           on word_last_i; unwritten words stay zero.
//           Build option INPUT_BLOCK_PACK_DBUF_EN adds an output register so a
//           new block can fill while the previous one waits for the consumer.
// Ports   : clk_i, rst_n_i              - clock, asynchronous active-low reset
//           word_i/word_valid_i/
//           word_last_i/word_ready_o    - input word stream
//           word_idx_o                  - slot the next accepted word goes to
//           block_o/block_valid_o/
//           block_last_o/block_words_o/
//           block_ready_i               - assembled block and its metadata
module input_block_pack
   import input_pack_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic [WORD_W-1:0]  word_i,
   input  logic               word_valid_i,
   input  logic               word_last_i,
   output logic               word_ready_o,
   output logic [IDX_W-1:0]   word_idx_o,
   output logic [BLOCK_W-1:0] block_o,
   output logic               block_valid_o,
   output logic               block_last_o,
   output logic [CNT_W-1:0]   block_words_o,
   input  logic               block_ready_i
);

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic               pend_last;
   logic [CNT_W-1:0]   pend_words;
   logic [BLOCK_W-1:0] fill_block;
   logic               fill_clear;
   logic               word_xfer;
   logic               closing;
   logic [CNT_W-1:0]   close_words;

   assign word_ready_o = (state == ST_FILL);
   assign word_xfer    = word_valid_i & word_ready_o;
   assign closing      = word_xfer & (word_last_i | (idx == IDX_W'(WORDS - 1)));
   assign close_words  = {1'b0, idx} + CNT_W'(1);
   assign word_idx_o   = idx;

   input_word_writer u_fill (
      .clk        (clk_i),
      .rst_n      (rst_n_i),
      .clear      (fill_clear),
      .load       (1'b0),
      .load_block ('0),
      .wr_en      (word_xfer),
      .wr_idx     (idx),
      .wr_word    (word_i),
      .block      (fill_block)
   );

`ifdef INPUT_BLOCK_PACK_DBUF_EN

   logic               out_valid;
   logic               out_last;
   logic [CNT_W-1:0]   out_words;
   logic [BLOCK_W-1:0] out_block;
   logic               out_free;
   logic               move_close;
   logic               move_hold;
   logic               move;
   logic               out_clear;
   logic [BLOCK_W-1:0] move_block;
   logic               move_last;
   logic [CNT_W-1:0]   move_words;

   // The output register can take a block this edge if it is empty or being drained.
   assign out_free   = ~out_valid | block_ready_i;
   assign move_close = closing & out_free;
   assign move_hold  = (state == ST_HOLD) & out_free;
   assign move       = move_close | move_hold;

   // A closing word bypasses the fill buffer so the move happens on its own edge.
   assign move_block = move_hold ? fill_block : insert_word(fill_block, idx, word_i);
   assign move_last  = move_hold ? pend_last  : word_last_i;
   assign move_words = move_hold ? pend_words : close_words;

   assign fill_clear = move;
   assign out_clear  = out_valid & block_ready_i & ~move;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= ST_FILL;
         idx        <= '0;
         pend_last  <= 1'b0;
         pend_words <= '0;
      end else if (state == ST_FILL) begin
         if (word_xfer) begin
            if (closing) begin
               idx <= '0;
               if (!out_free) begin
                  state      <= ST_HOLD;
                  pend_last  <= word_last_i;
                  pend_words <= close_words;
               end
            end else begin
               idx <= idx + IDX_W'(1);
            end
         end
      end else if (out_free) begin
         state      <= ST_FILL;
         pend_last  <= 1'b0;
         pend_words <= '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_words <= '0;
      end else if (move) begin
         out_valid <= 1'b1;
         out_last  <= move_last;
         out_words <= move_words;
      end else if (out_clear) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_words <= '0;
      end
   end

   input_word_writer u_out (
      .clk        (clk_i),
      .rst_n      (rst_n_i),
      .clear      (out_clear),
      .load       (move),
      .load_block (move_block),
      .wr_en      (1'b0),
      .wr_idx     ('0),
      .wr_word    ('0),
      .block      (out_block)
   );

   assign block_o       = out_block;
   assign block_valid_o = out_valid;
   assign block_last_o  = out_last;
   assign block_words_o = out_words;

`else

   assign fill_clear = (state == ST_HOLD) & block_ready_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= ST_FILL;
         idx        <= '0;
         pend_last  <= 1'b0;
         pend_words <= '0;
      end else if (state == ST_FILL) begin
         if (word_xfer) begin
            if (closing) begin
               state      <= ST_HOLD;
               idx        <= '0;
               pend_last  <= word_last_i;
               pend_words <= close_words;
            end else begin
               idx <= idx + IDX_W'(1);
            end
         end
      end else if (block_ready_i) begin
         state      <= ST_FILL;
         pend_last  <= 1'b0;
         pend_words <= '0;
      end
   end

   assign block_o       = fill_block;
   assign block_valid_o = (state == ST_HOLD);
   assign block_last_o  = pend_last;
   assign block_words_o = pend_words;

`endif

endmodule

// File: tb/tb_input_block_pack.sv
// tb/tb_input_block_pack.sv - directed self-checking bench for input_block_pack
module tb_input_block_pack;
   import input_pack_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [WORD_W-1:0]  word;
   logic               word_valid;
   logic               word_last;
   logic               word_ready;
   logic [IDX_W-1:0]   word_idx;
   logic [BLOCK_W-1:0] block;
   logic               block_valid;
   logic               block_last;
   logic [CNT_W-1:0]   block_words;
   logic               block_ready;

   int checks   = 0;
   int failures = 0;
   int stalls   = 0;
   logic [BLOCK_W-1:0] exp_blk;

   always #5 clk = ~clk;

   input_block_pack dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .word_i        (word),
      .word_valid_i  (word_valid),
      .word_last_i   (word_last),
      .word_ready_o  (word_ready),
      .word_idx_o    (word_idx),
      .block_o       (block),
      .block_valid_o (block_valid),
      .block_last_o  (block_last),
      .block_words_o (block_words),
      .block_ready_i (block_ready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_block(input string tag, input logic [BLOCK_W-1:0] exp);
      for (int k = 0; k < WORDS; k++)
         chk($sformatf("%s_w%0d", tag, k), block[k*WORD_W +: WORD_W], exp[k*WORD_W +: WORD_W]);
   endtask

   // Called at a falling edge; offers one word and returns at the falling edge after acceptance.
   task automatic send(input logic [63:0] w, input logic l);
      int n;
      n = 0;
      while (!word_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      stalls += n;
      if (n >= 40) chk("send_timeout", {63'd0, word_ready}, 64'd1);
      word_valid = 1'b1;
      word       = w;
      word_last  = l;
      @(negedge clk);
      word_valid = 1'b0;
      word_last  = 1'b0;
   endtask

   task automatic release_blk();
      block_ready = 1'b1;
      @(negedge clk);
      block_ready = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      word        = '0;
      word_valid  = 1'b0;
      word_last   = 1'b0;
      block_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("rst_ready", {63'd0, word_ready}, 64'd1);
      chk("rst_valid", {63'd0, block_valid}, 64'd0);
      chk("rst_last", {63'd0, block_last}, 64'd0);
      chk("rst_words", {59'd0, block_words}, 64'd0);
      chk("rst_idx", {60'd0, word_idx}, 64'd0);
      chk_block("rst_blk", '0);

`ifndef INPUT_BLOCK_PACK_DBUF_EN
      // Full block 0..F with an always-ready consumer.
      block_ready = 1'b1;
      exp_blk = '0;
      for (int k = 0; k < WORDS; k++) begin
         exp_blk[k*WORD_W +: WORD_W] = 64'(k);
         send(64'(k), 1'b0);
         if (k < WORDS - 1) chk($sformatf("t1_idx%0d", k), {60'd0, word_idx}, 64'(k + 1));
      end
      chk("t1_stalls", 64'(stalls), 64'd0);
      chk("t1_valid", {63'd0, block_valid}, 64'd1);
      chk("t1_ready_low", {63'd0, word_ready}, 64'd0);
      chk("t1_words", {59'd0, block_words}, 64'd16);
      chk("t1_last", {63'd0, block_last}, 64'd0);
      chk_block("t1_blk", exp_blk);
      @(negedge clk);
      chk("t1_valid_after", {63'd0, block_valid}, 64'd0);
      chk("t1_ready_after", {63'd0, word_ready}, 64'd1);
      chk("t1_idx_after", {60'd0, word_idx}, 64'd0);

      // Short message A,B,C with last on C.
      block_ready = 1'b0;
      send(64'hA, 1'b0);
      send(64'hB, 1'b0);
      send(64'hC, 1'b1);
      exp_blk = '0;
      exp_blk[191:0] = {64'hC, 64'hB, 64'hA};
      chk("t2_valid", {63'd0, block_valid}, 64'd1);
      chk("t2_words", {59'd0, block_words}, 64'd3);
      chk("t2_last", {63'd0, block_last}, 64'd1);
      chk_block("t2_blk", exp_blk);

      // Consumer stalled 20 cycles with a word offered the whole time.
      word_valid = 1'b1;
      word       = 64'h55;
      word_last  = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk($sformatf("t3_valid%0d", c), {63'd0, block_valid}, 64'd1);
         chk($sformatf("t3_ready%0d", c), {63'd0, word_ready}, 64'd0);
         chk($sformatf("t3_words%0d", c), {59'd0, block_words}, 64'd3);
         chk($sformatf("t3_w2_%0d", c), block[191:128], 64'hC);
      end
      word_valid = 1'b0;
      word_last  = 1'b0;
      chk("t3_last", {63'd0, block_last}, 64'd1);
      chk("t3_idx", {60'd0, word_idx}, 64'd0);
      chk_block("t3_blk", exp_blk);
      release_blk();
      chk("t3_valid_rel", {63'd0, block_valid}, 64'd0);
      chk("t3_ready_rel", {63'd0, word_ready}, 64'd1);
      chk("t3_idx_rel", {60'd0, word_idx}, 64'd0);
      chk_block("t3_zero", '0);

      // Asynchronous reset mid-block.
      for (int k = 0; k < 7; k++) send(64'h100 + 64'(k), 1'b0);
      chk("t4_idx7", {60'd0, word_idx}, 64'd7);
      #2 rst_n = 1'b0;
      #1;
      chk("t4_idx_rst", {60'd0, word_idx}, 64'd0);
      chk("t4_valid_rst", {63'd0, block_valid}, 64'd0);
      chk("t4_words_rst", {59'd0, block_words}, 64'd0);
      chk("t4_last_rst", {63'd0, block_last}, 64'd0);
      chk_block("t4_blk_rst", '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t4_ready_rel", {63'd0, word_ready}, 64'd1);
      exp_blk = '0;
      for (int k = 0; k < WORDS; k++) begin
         exp_blk[k*WORD_W +: WORD_W] = 64'h200 + 64'(k);
         send(64'h200 + 64'(k), k == WORDS - 1);
      end
      chk("t4_words", {59'd0, block_words}, 64'd16);
      chk("t4_last16", {63'd0, block_last}, 64'd1);
      chk_block("t4_blk", exp_blk);
      release_blk();

      // Single-word message after idle cycles.
      repeat (3) @(negedge clk);
      send(64'hDEAD_BEEF_0123_4567, 1'b1);
      exp_blk = '0;
      exp_blk[63:0] = 64'hDEAD_BEEF_0123_4567;
      chk("t5_words1", {59'd0, block_words}, 64'd1);
      chk("t5_last1", {63'd0, block_last}, 64'd1);
      chk_block("t5_blk1", exp_blk);
      release_blk();

      // Gapped words; last with valid low must be ignored.
      send(64'h11, 1'b0);
      repeat (2) @(negedge clk);
      send(64'h22, 1'b0);
      word_last = 1'b1;
      repeat (2) @(negedge clk);
      word_last = 1'b0;
      chk("t5_gap_valid", {63'd0, block_valid}, 64'd0);
      chk("t5_gap_idx", {60'd0, word_idx}, 64'd2);
      send(64'h33, 1'b1);
      exp_blk = '0;
      exp_blk[191:0] = {64'h33, 64'h22, 64'h11};
      chk("t5_gap_words", {59'd0, block_words}, 64'd3);
      chk("t5_gap_last", {63'd0, block_last}, 64'd1);
      chk_block("t5_gap_blk", exp_blk);
      release_blk();
      chk("t5_end_valid", {63'd0, block_valid}, 64'd0);
`else
      // Back-to-back blocks with an always-ready consumer: no stalls.
      block_ready = 1'b1;
      stalls = 0;
      exp_blk = '0;
      for (int k = 0; k < 2 * WORDS; k++) begin
         send(64'(k), 1'b0);
         if (k == WORDS - 1) begin
            chk("d1_valid0", {63'd0, block_valid}, 64'd1);
            chk("d1_words0", {59'd0, block_words}, 64'd16);
            chk("d1_w15_0", block[1023:960], 64'd15);
         end
      end
      for (int k = 0; k < WORDS; k++) exp_blk[k*WORD_W +: WORD_W] = 64'(WORDS + k);
      chk("d1_stalls", 64'(stalls), 64'd0);
      chk("d1_valid1", {63'd0, block_valid}, 64'd1);
      chk("d1_ready", {63'd0, word_ready}, 64'd1);
      chk_block("d1_blk1", exp_blk);
      @(negedge clk);
      chk("d1_drained", {63'd0, block_valid}, 64'd0);

      // Stalled consumer: second block closes and blocks input.
      block_ready = 1'b0;
      for (int k = 0; k < WORDS; k++) send(64'h300 + 64'(k), 1'b0);
      chk("d2_valid", {63'd0, block_valid}, 64'd1);
      chk("d2_ready_a", {63'd0, word_ready}, 64'd1);
      chk("d2_w0_a", block[63:0], 64'h300);
      exp_blk = '0;
      for (int k = 0; k < WORDS; k++) begin
         exp_blk[k*WORD_W +: WORD_W] = 64'h400 + 64'(k);
         send(64'h400 + 64'(k), 1'b0);
      end
      chk("d2_ready_b", {63'd0, word_ready}, 64'd0);
      chk("d2_w0_held", block[63:0], 64'h300);
      release_blk();
      chk("d2_valid_b", {63'd0, block_valid}, 64'd1);
      chk("d2_ready_rel", {63'd0, word_ready}, 64'd1);
      chk_block("d2_blk_b", exp_blk);
      release_blk();
      chk("d2_end_valid", {63'd0, block_valid}, 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
